imm_rotate_encoder: RTL and testbench
=====================================

Name: imm_rotate_encoder

Overview:
- Inverse of the operand-2 immediate path: takes a 32-bit constant and searches for the ARM data-processing immediate encoding {rotate_imm[3:0], imm8[7:0]} such that ROR(zero-extended imm8, 2*rotate_imm) equals the constant.
- Multi-cycle, valid/ready in and out. Checks LANES rotations per cycle.
- Used by the instruction-ROM builder / self-test harness and the bench scoreboard to produce and check shifter_operand fields.

Parameters:
- LANES, 1, rotations checked per cycle; legal values 1, 2, 4, 8, 16; other values are a compile-time error.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset; asynchronous, active-high
- in_valid  input  1  request valid
- in_ready  output  1  block can accept a request (high only in IDLE)
- value  input  32  constant to encode; sampled on accept
- out_valid  output  1  result valid; held until accepted
- out_ready  input  1  consumer accepts result
- encodable  output  1  1 = encoding found; 0 = constant not representable
- shift_operand  output  12  {rotate_imm, imm8}; 12'h000 when encodable=0

Behaviour:
- Reset (asynchronous, any state) clears all state. Next state is IDLE. in_ready=1, out_valid=0, encodable=0, shift_operand=0. An in-flight search is discarded.
- FSM states: IDLE, SEARCH, DONE.
- IDLE:
  - in_ready=1.
  - Accept on the edge where in_valid && in_ready.
  - On accept: cand <= value, rot <= 0, next state SEARCH.
- SEARCH:
  - in_ready=0.
  - Lane k (k=0..LANES-1) tests c_k = ROL(cand, 2k). Lane k fits when c_k[31:8]==0.
  - The lowest-numbered fitting lane wins. Result: rotate_imm = rot+k, imm8 = c_k[7:0], encodable=1, next state DONE.
  - If no lane fits and rot+LANES==16: encodable=0, shift_operand=0, next state DONE.
  - Otherwise: cand <= ROL(cand, 2*LANES), rot <= rot+LANES, stay in SEARCH.
  - rot is 5 bits internally, so rot+LANES==16 does not overflow.
- DONE:
  - out_valid=1. encodable and shift_operand are registered and stable.
  - On out_valid && out_ready: out_valid deasserts on that edge, next state IDLE.
  - The next request can be accepted one cycle later (no same-cycle turnaround).
- Result rule: the smallest rotate_imm wins.
  - value 0 gives {0, 8'h00}.
  - A constant with several encodings always reports the minimum rotate.
- Latency, counted from the accept edge to the edge that raises out_valid:
  - encodable: floor(r/LANES)+1 cycles, where r is the winning rotate;
  - unencodable: 16/LANES cycles.
- Outputs are registered only. There is no combinational path from value or in_valid to any output.
- in_valid while busy is ignored. The requester holds value until accepted.
- out_ready low in DONE stalls indefinitely with outputs unchanged.

Decomposition:
- Shared defines header (alongside the existing `LSL/`LSR/`ASR/`ROR defines):
  - ROT_W=4, IMM_W=8;
  - state encodings IDLE=2'd0, SEARCH=2'd1, DONE=2'd2.
- One combinational sub-module, rot_fit_check:
  - input cand[31:0] and lane offset k;
  - outputs fit and imm8 = ROL(cand, 2k)[7:0].
  - Instantiated LANES times via generate.
- Priority pick and FSM stay in the top module.

Test Plan:
- LANES=1, value=32'h000000FF -> out_valid 1 cycle after accept; encodable=1, shift_operand=12'h0FF.
- LANES=1, value=32'hFF000000 -> 5 cycles; encodable=1, shift_operand=12'h4FF. value=32'hF000000F -> 3 cycles; 12'h2FF.
- LANES=1, value=32'h00000104 -> 16 cycles; 12'hF41. value=32'h00000101 -> 16 cycles; encodable=0, shift_operand=12'h000.
- LANES=4, value=32'hFF000000 -> 2 cycles; 12'h4FF. LANES=16, value=32'h00000104 -> 1 cycle; 12'hF41. LANES=16, value=32'h00000000 -> 1 cycle; 12'h000 (minimum rotate).
- Handshake: hold out_ready=0 for 10 cycles in DONE -> outputs stable, in_ready=0. A second in_valid pulse during SEARCH is not accepted. out_ready=1 -> IDLE, in_ready=1 next cycle, a back-to-back request is accepted.
- Assert rst mid-SEARCH (value=32'h00000101, cycle 7) -> outputs cleared immediately (asynchronously). After release, a new request 32'h000000FF completes normally with 12'h0FF.

Source files
------------

// File: rtl/imm_rotate_encoder_pkg.sv
// Shared widths, FSM state encoding and rotate helper for the immediate encoder.
package imm_rotate_encoder_pkg;

    localparam int unsigned ROT_W = 4;
    localparam int unsigned IMM_W = 8;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSearch = 2'd1,
        StDone   = 2'd2
    } state_e;

    function automatic logic [31:0] rol32(input logic [31:0] x, input logic [4:0] sh);
        if (sh == 5'd0) begin
            return x;
        end
        return (x << sh) | (x >> (6'd32 - {1'b0, sh}));
    endfunction

endpackage

// File: rtl/imm_rotate_encoder_rot_fit_check.sv
// One search lane: does ROL(cand, 2k) fit in an 8-bit immediate?
module imm_rotate_encoder_rot_fit_check
    import imm_rotate_encoder_pkg::*;
(
    input  logic [31:0]      cand,
    input  logic [ROT_W-1:0] k,
    output logic             fit,
    output logic [IMM_W-1:0] imm8
);

    logic [31:0] rotated;

    always_comb begin
        rotated = rol32(cand, {k, 1'b0});
        fit     = (rotated[31:IMM_W] == '0);
        imm8    = rotated[IMM_W-1:0];
    end

endmodule

// File: rtl/imm_rotate_encoder.sv
// Finds the minimum-rotate ARM operand-2 immediate encoding of a 32-bit constant,
// testing LANES rotations per cycle behind valid/ready handshakes.
module imm_rotate_encoder
    import imm_rotate_encoder_pkg::*;
#(
    parameter int unsigned LANES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] value,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        encodable,
    output logic [11:0] shift_operand
);

    localparam bit LanesOk = (LANES == 1) || (LANES == 2) || (LANES == 4) ||
                             (LANES == 8) || (LANES == 16);

    if (!LanesOk) begin : g_bad_lanes
        $error("imm_rotate_encoder: LANES must be 1, 2, 4, 8 or 16");
    end

    // ROL by 32 is the identity, so LANES=16 folds to a zero shift.
    localparam logic [4:0] StepSh = 5'((2 * LANES) % 32);
    localparam logic [4:0] RotEnd = 5'd16;

    state_e      state_q, state_d;
    logic [31:0] cand_q, cand_d;
    logic [4:0]  rot_q, rot_d;
    logic        enc_q, enc_d;
    logic [11:0] so_q, so_d;

    logic [LANES-1:0] lane_fit;
    logic [IMM_W-1:0] lane_imm [LANES];

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        imm_rotate_encoder_rot_fit_check u_fit (
            .cand (cand_q),
            .k    (ROT_W'(k)),
            .fit  (lane_fit[k]),
            .imm8 (lane_imm[k])
        );
    end

    logic             found;
    logic [ROT_W-1:0] win_k;
    logic [IMM_W-1:0] win_imm;

    // Scan downwards so the lowest fitting lane (smallest rotate) wins.
    always_comb begin
        found   = 1'b0;
        win_k   = '0;
        win_imm = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (lane_fit[i]) begin
                found   = 1'b1;
                win_k   = ROT_W'(i);
                win_imm = lane_imm[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        rot_d   = rot_q;
        enc_d   = enc_q;
        so_d    = so_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    cand_d  = value;
                    rot_d   = '0;
                    state_d = StSearch;
                end
            end
            StSearch: begin
                if (found) begin
                    enc_d   = 1'b1;
                    so_d    = {rot_q[ROT_W-1:0] + win_k, win_imm};
                    state_d = StDone;
                end else if (rot_q + 5'(LANES) == RotEnd) begin
                    enc_d   = 1'b0;
                    so_d    = '0;
                    state_d = StDone;
                end else begin
                    cand_d = rol32(cand_q, StepSh);
                    rot_d  = rot_q + 5'(LANES);
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cand_q  <= '0;
            rot_q   <= '0;
            enc_q   <= 1'b0;
            so_q    <= '0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            rot_q   <= rot_d;
            enc_q   <= enc_d;
            so_q    <= so_d;
        end
    end

    assign in_ready      = (state_q == StIdle);
    assign out_valid     = (state_q == StDone);
    assign encodable     = enc_q;
    assign shift_operand = so_q;

endmodule

// File: tb/tb_imm_rotate_encoder.sv
// Directed bench for imm_rotate_encoder at LANES = 1, 4 and 16.
module tb_imm_rotate_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] value = '0;
    logic [2:0]  in_valid = '0;
    logic [2:0]  out_ready = '0;
    logic [2:0]  in_ready;
    logic [2:0]  out_valid;
    logic [2:0]  encodable;
    logic [11:0] so [3];

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    imm_rotate_encoder #(.LANES(1)) u_l1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .value(value), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .encodable(encodable[0]), .shift_operand(so[0])
    );
    imm_rotate_encoder #(.LANES(4)) u_l4 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .value(value), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .encodable(encodable[1]), .shift_operand(so[1])
    );
    imm_rotate_encoder #(.LANES(16)) u_l16 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .value(value), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .encodable(encodable[2]), .shift_operand(so[2])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept, wait for out_valid (bounded), check latency/result, do not retire.
    task automatic launch_and_wait(input int idx, input logic [31:0] v, input int exp_lat,
                                   input logic exp_enc, input logic [11:0] exp_so,
                                   input string tag);
        int cyc;
        value = v;
        in_valid[idx] = 1'b1;
        tick();
        in_valid[idx] = 1'b0;
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!out_valid[idx] && cyc < 40);
        chk({tag, " latency"}, 32'(cyc), 32'(exp_lat));
        chk({tag, " encodable"}, 32'(encodable[idx]), 32'(exp_enc));
        chk({tag, " shift_operand"}, 32'(so[idx]), 32'(exp_so));
    endtask

    task automatic retire(input int idx, input string tag);
        out_ready[idx] = 1'b1;
        tick();
        out_ready[idx] = 1'b0;
        chk({tag, " out_valid drop"}, 32'(out_valid[idx]), 32'd0);
        chk({tag, " in_ready back"}, 32'(in_ready[idx]), 32'd1);
    endtask

    initial begin
        logic [11:0] held_so;

        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset in_ready[%0d]", i), 32'(in_ready[i]), 32'd1);
            chk($sformatf("reset out_valid[%0d]", i), 32'(out_valid[i]), 32'd0);
            chk($sformatf("reset encodable[%0d]", i), 32'(encodable[i]), 32'd0);
            chk($sformatf("reset so[%0d]", i), 32'(so[i]), 32'd0);
        end
        rst = 1'b0;
        tick();

        // LANES=1 directed vectors
        launch_and_wait(0, 32'h000000FF, 1, 1'b1, 12'h0FF, "l1 0xFF");
        retire(0, "l1 0xFF");
        launch_and_wait(0, 32'hF000000F, 3, 1'b1, 12'h2FF, "l1 0xF000000F");
        retire(0, "l1 0xF000000F");
        launch_and_wait(0, 32'h00000104, 16, 1'b1, 12'hF41, "l1 0x104");
        retire(0, "l1 0x104");
        launch_and_wait(0, 32'h00000101, 16, 1'b0, 12'h000, "l1 0x101");
        retire(0, "l1 0x101");

        // LANES=4 and LANES=16
        launch_and_wait(1, 32'hFF000000, 2, 1'b1, 12'h4FF, "l4 0xFF000000");
        retire(1, "l4 0xFF000000");
        launch_and_wait(2, 32'h00000104, 1, 1'b1, 12'hF41, "l16 0x104");
        retire(2, "l16 0x104");
        launch_and_wait(2, 32'h00000000, 1, 1'b1, 12'h000, "l16 zero");
        retire(2, "l16 zero");
        launch_and_wait(2, 32'h00000101, 1, 1'b0, 12'h000, "l16 0x101");
        retire(2, "l16 0x101");

        // Handshake: ignored in_valid during SEARCH, stall in DONE, back-to-back
        value = 32'hFF000000;
        in_valid[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        tick();
        chk("hs in_ready in search", 32'(in_ready[0]), 32'd0);
        value = 32'h000000FF;
        in_valid[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        value = 32'h12345678;
        for (int i = 0; i < 10 && !out_valid[0]; i++) tick();
        chk("hs out_valid", 32'(out_valid[0]), 32'd1);
        chk("hs result ignores pulse", 32'(so[0]), 32'h4FF);
        held_so = so[0];
        for (int i = 0; i < 10; i++) tick();
        chk("hs stall out_valid", 32'(out_valid[0]), 32'd1);
        chk("hs stall in_ready", 32'(in_ready[0]), 32'd0);
        chk("hs stall so", 32'(so[0]), 32'(held_so));
        chk("hs stall encodable", 32'(encodable[0]), 32'd1);
        retire(0, "hs");
        launch_and_wait(0, 32'hF000000F, 3, 1'b1, 12'h2FF, "hs b2b");
        retire(0, "hs b2b");

        // Leave a held result, then reset mid-search
        launch_and_wait(0, 32'hFF000000, 5, 1'b1, 12'h4FF, "pre-rst");
        retire(0, "pre-rst");
        value = 32'h00000101;
        in_valid[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        chk("mid-search in_ready", 32'(in_ready[0]), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("async rst in_ready", 32'(in_ready[0]), 32'd1);
        chk("async rst out_valid", 32'(out_valid[0]), 32'd0);
        chk("async rst encodable", 32'(encodable[0]), 32'd0);
        chk("async rst so", 32'(so[0]), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        launch_and_wait(0, 32'h000000FF, 1, 1'b1, 12'h0FF, "post-rst 0xFF");
        retire(0, "post-rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
